// File: rtl/toy_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : toy_bus_pkg
// Desc   : ToyBus request payload type, width constants and skid-buffer states.
// Rev    : 1.0  initial release
// ============================================================================
package toy_bus_pkg;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_STRB_W = 32;
    localparam int REQ_DATA_W = 256;
    localparam int REQ_ID_W   = 4;
    localparam int REQ_SB_W   = 10;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_STRB_W-1:0] strb;
        logic [REQ_DATA_W-1:0] data;
        logic                  opcode;
        logic [REQ_ID_W-1:0]   src_id;
        logic [REQ_ID_W-1:0]   tgt_id;
        logic [REQ_SB_W-1:0]   sideband;
    } toy_bus_req_t;

    localparam int REQ_W = $bits(toy_bus_req_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/toy_bus_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : toy_bus_skid_buf
// Desc   : 2-entry registered valid/ready slice carrying one ToyBus request.
// Rev    : 1.0  initial release
// ============================================================================
module toy_bus_skid_buf
    import toy_bus_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  toy_bus_req_t in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output toy_bus_req_t out_data
);

    skid_state_e  r_state;
    skid_state_e  w_state_nxt;
    toy_bus_req_t r_main;
    toy_bus_req_t r_skid;
    logic         r_space_ok;
    logic         w_push;
    logic         w_pop;

    assign in_rdy   = r_space_ok;
    assign out_vld  = (r_state != EMPTY);
    assign out_data = r_main;
    assign w_push   = in_vld && r_space_ok;
    assign w_pop    = out_vld && out_rdy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_push) w_state_nxt = HALF;
            HALF: begin
                if (w_push && !w_pop)      w_state_nxt = FULL;
                else if (w_pop && !w_push) w_state_nxt = EMPTY;
            end
            FULL:    if (w_pop) w_state_nxt = HALF;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Ready is registered from the next state so upstream never sees a comb path from out_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_space_ok <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_space_ok <= (w_state_nxt != FULL);
            case (r_state)
                EMPTY: if (w_push) r_main <= in_data;
                HALF: begin
                    if (w_push && w_pop) r_main <= in_data;
                    else if (w_push)     r_skid <= in_data;
                end
                FULL:    if (w_pop) r_main <= r_skid;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/toy_bus_arb_node_fetch_req.sv
`default_nettype none
// ============================================================================
// Module : toy_bus_arb_node_fetch_req
// Desc   : 2:1 round-robin ToyBus request merge feeding a registered skid buffer.
// Rev    : 1.0  initial release
// ============================================================================
module toy_bus_arb_node_fetch_req
    import toy_bus_pkg::*;
#(
    parameter int ADDR_W = REQ_ADDR_W,
    parameter int STRB_W = REQ_STRB_W,
    parameter int DATA_W = REQ_DATA_W,
    parameter int ID_W   = REQ_ID_W,
    parameter int SB_W   = REQ_SB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic [STRB_W-1:0] in0_strb,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_opcode,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    input  logic [SB_W-1:0]   in0_sideband,
    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic [STRB_W-1:0] in1_strb,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_opcode,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,
    input  logic [SB_W-1:0]   in1_sideband,
    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic [ADDR_W-1:0] out0_addr,
    output logic [STRB_W-1:0] out0_strb,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_opcode,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id,
    output logic [SB_W-1:0]   out0_sideband
);

    toy_bus_req_t w_in0;
    toy_bus_req_t w_in1;
    toy_bus_req_t w_sel;
    toy_bus_req_t w_out;
    logic         w_space_ok;
    logic         w_req0;
    logic         w_req1;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         r_rr_ptr;

    // Parameters are expected to match the package widths the struct is built from.
    assign w_in0 = {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband};
    assign w_in1 = {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband};

    assign w_req0 = in0_vld && w_space_ok;
    assign w_req1 = in1_vld && w_space_ok;
    assign w_gnt0 = w_req0 && (!w_req1 || !r_rr_ptr);
    assign w_gnt1 = w_req1 && (!w_req0 ||  r_rr_ptr);

    assign in0_rdy = w_gnt0;
    assign in1_rdy = w_gnt1;
    assign w_sel   = w_gnt1 ? w_in1 : w_in0;

    // Pointer lands on the loser after every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt0 || w_gnt1) begin
            r_rr_ptr <= !w_gnt1;
        end
    end

    toy_bus_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (w_gnt0 || w_gnt1),
        .in_rdy   (w_space_ok),
        .in_data  (w_sel),
        .out_vld  (out0_vld),
        .out_rdy  (out0_rdy),
        .out_data (w_out)
    );

    assign {out0_addr, out0_strb, out0_data, out0_opcode,
            out0_src_id, out0_tgt_id, out0_sideband} = w_out;

endmodule
`default_nettype wire

// File: tb/tb_toy_bus_arb_node_fetch_req.sv
`default_nettype none
// ============================================================================
// Module : tb_toy_bus_arb_node_fetch_req
// Desc   : Directed and randomised self-checking bench for the 2:1 request merge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_toy_bus_arb_node_fetch_req;
    import toy_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic in0_vld, in1_vld, in0_rdy, in1_rdy, out0_vld, out0_rdy;
    toy_bus_req_t b0, b1, o;
    logic [REQ_ADDR_W-1:0] out0_addr;
    logic [REQ_STRB_W-1:0] out0_strb;
    logic [REQ_DATA_W-1:0] out0_data;
    logic                  out0_opcode;
    logic [REQ_ID_W-1:0]   out0_src_id, out0_tgt_id;
    logic [REQ_SB_W-1:0]   out0_sideband;

    assign o = {out0_addr, out0_strb, out0_data, out0_opcode, out0_src_id, out0_tgt_id, out0_sideband};

    toy_bus_arb_node_fetch_req dut (
        .clk(clk), .rst_n(rst_n),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy),
        .in0_addr(b0.addr), .in0_strb(b0.strb), .in0_data(b0.data), .in0_opcode(b0.opcode),
        .in0_src_id(b0.src_id), .in0_tgt_id(b0.tgt_id), .in0_sideband(b0.sideband),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy),
        .in1_addr(b1.addr), .in1_strb(b1.strb), .in1_data(b1.data), .in1_opcode(b1.opcode),
        .in1_src_id(b1.src_id), .in1_tgt_id(b1.tgt_id), .in1_sideband(b1.sideband),
        .out0_vld(out0_vld), .out0_rdy(out0_rdy),
        .out0_addr(out0_addr), .out0_strb(out0_strb), .out0_data(out0_data),
        .out0_opcode(out0_opcode), .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id),
        .out0_sideband(out0_sideband)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    toy_bus_req_t sb_q[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic toy_bus_req_t mk(input int src, input logic [31:0] addr);
        toy_bus_req_t r;
        r.addr     = addr;
        r.strb     = 32'hFFFF_FFFF;
        r.data     = {8{addr ^ 32'hA5A5_0000}};
        r.opcode   = addr[0];
        r.src_id   = 4'(src);
        r.tgt_id   = 4'(~src);
        r.sideband = addr[9:0];
        return r;
    endfunction

    function automatic toy_bus_req_t rnd(input int src);
        toy_bus_req_t r;
        for (int i = 0; i < 8; i++) r.data[i*32 +: 32] = $urandom;
        r.addr     = $urandom;
        r.strb     = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
        r.opcode   = 1'($urandom_range(0, 1));
        r.src_id   = 4'(src);
        r.tgt_id   = 4'($urandom_range(0, 15));
        r.sideband = 10'($urandom_range(0, 1023));
        return r;
    endfunction

    // Called between input setup and the active edge: retire outputs, then queue accepts.
    task automatic sb_step();
        if (out0_vld && out0_rdy) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_beat", 512'(1'b1), 512'(1'b0));
            end else begin
                check("sb_beat", 512'(o), 512'(sb_q[0]));
                void'(sb_q.pop_front());
                n_out++;
            end
        end
        if (in0_vld && in0_rdy) sb_q.push_back(b0);
        if (in1_vld && in1_rdy) sb_q.push_back(b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in0_vld = 1'b0;
        in1_vld = 1'b0;
        out0_rdy = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: sim time limit hit, expected normal finish");
        $fatal(1, "watchdog expired");
    end

    int n0, n1, acc5, out5, wait0, wait1, max0, max1;
    logic hs0, hs1;
    logic [31:0] ea;
    int ev[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int eo[9] = '{0, 0, 0, 0, 0, 0, 1, 2, 0};
    int er[9] = '{1, 1, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        in0_vld = 1'b1; in1_vld = 1'b1; out0_rdy = 1'b0;
        b0 = mk(0, 32'h0); b1 = mk(1, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_vld", 512'(out0_vld), 512'(1'b0));
        check("rst_in0_rdy", 512'(in0_rdy), 512'(1'b0));
        check("rst_in1_rdy", 512'(in1_rdy), 512'(1'b0));
        check("rst_payload", 512'(o), 512'(0));

        // Reset mid-traffic: fill to FULL, then pull rst_n low between edges.
        @(negedge clk);
        in0_vld = 1'b0; in1_vld = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        in0_vld = 1'b1; b0 = mk(0, 32'h500);
        @(negedge clk);
        b0 = mk(0, 32'h501);
        @(negedge clk);
        #1;
        check("full_in0_rdy", 512'(in0_rdy), 512'(1'b0));
        check("full_out_vld", 512'(out0_vld), 512'(1'b1));
        #1 rst_n = 1'b0;
        #1;
        check("async_out_vld", 512'(out0_vld), 512'(1'b0));
        check("async_in0_rdy", 512'(in0_rdy), 512'(1'b0));
        check("async_payload", 512'(o), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in0_rdy_pre", 512'(in0_rdy), 512'(1'b0));
        @(negedge clk);
        #1;
        check("rel_in0_rdy", 512'(in0_rdy), 512'(1'b1));
        check("rel_out_vld", 512'(out0_vld), 512'(1'b0));
        #1 in0_vld = 1'b0;

        // Single stream, full throughput.
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            out0_rdy = 1'b1;
            in0_vld = (k < 16);
            b0 = mk(0, 32'h1000 + 32'(k));
            #1;
            if (k < 16) check("t2_in0_rdy", 512'(in0_rdy), 512'(1'b1));
            if (k > 0) begin
                ea = 32'h1000 + 32'(k - 1);
                check("t2_out_vld", 512'(out0_vld), 512'(1'b1));
                check("t2_out_addr", 512'(out0_addr), 512'(ea));
            end
            sb_step();
            @(negedge clk);
        end
        in0_vld = 1'b0;
        #1;
        check("t2_idle", 512'(out0_vld), 512'(1'b0));
        @(negedge clk);

        // Contention: strict alternation starting at in0.
        do_reset();
        n0 = 0; n1 = 0;
        for (int k = 0; k <= 8; k++) begin
            out0_rdy = 1'b1;
            in0_vld = (k < 8); in1_vld = (k < 8);
            b0 = mk(0, 32'h2000 + 32'(n0));
            b1 = mk(1, 32'h3000 + 32'(n1));
            #1;
            if (k < 8) begin
                check("t3_in0_rdy", 512'(in0_rdy), 512'(k % 2 == 0));
                check("t3_in1_rdy", 512'(in1_rdy), 512'(k % 2 == 1));
            end
            if (k > 0) check("t3_src_id", 512'(out0_src_id), 512'((k - 1) % 2));
            hs0 = in0_vld && in0_rdy; hs1 = in1_vld && in1_rdy;
            sb_step();
            if (hs0) n0++;
            if (hs1) n1++;
            @(negedge clk);
        end
        check("t3_in0_count", 512'(n0), 512'(4));
        check("t3_in1_count", 512'(n1), 512'(4));

        // Backpressure: two beats held, payload frozen, order kept on release.
        do_reset();
        n0 = 0;
        for (int c = 0; c < 9; c++) begin
            out0_rdy = (c >= 5);
            in0_vld = (c < 7);
            b0 = mk(0, 32'h4000 + 32'(n0));
            #1;
            check("t4_in0_rdy", 512'(in0_rdy), 512'(er[c]));
            check("t4_in1_rdy", 512'(in1_rdy), 512'(1'b0));
            check("t4_out_vld", 512'(out0_vld), 512'(ev[c]));
            if (ev[c] != 0) check("t4_out_beat", 512'(o), 512'(mk(0, 32'h4000 + 32'(eo[c]))));
            hs0 = in0_vld && in0_rdy;
            sb_step();
            if (hs0) n0++;
            @(negedge clk);
        end

        // Toggling downstream ready with both inputs busy.
        do_reset();
        n0 = 0; n1 = 0; acc5 = 0; out5 = n_out;
        for (int c = 0; c < 20; c++) begin
            out0_rdy = (c >= 16) || (c % 2 == 1);
            in0_vld = (c < 16); in1_vld = (c < 16);
            b0 = mk(0, 32'h5000 + 32'(n0));
            b1 = mk(1, 32'h6000 + 32'(n1));
            #1;
            hs0 = in0_vld && in0_rdy; hs1 = in1_vld && in1_rdy;
            sb_step();
            if (hs0) begin n0++; acc5++; end
            if (hs1) begin n1++; acc5++; end
            @(negedge clk);
        end
        check("t5_accepted", 512'(acc5), 512'(9));
        check("t5_delivered", 512'(n_out - out5), 512'(9));
        check("t5_sb_empty", 512'(sb_q.size()), 512'(0));

        // Random valid/ready soak.
        do_reset();
        wait0 = 0; wait1 = 0; max0 = 0; max1 = 0; hs0 = 1'b0; hs1 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (hs0) in0_vld = 1'b0;
            if (hs1) in1_vld = 1'b0;
            if (!in0_vld && $urandom_range(0, 1) != 0) begin in0_vld = 1'b1; b0 = rnd(0); end
            if (!in1_vld && $urandom_range(0, 1) != 0) begin in1_vld = 1'b1; b1 = rnd(1); end
            out0_rdy = ($urandom_range(0, 3) != 0);
            #1;
            hs0 = in0_vld && in0_rdy; hs1 = in1_vld && in1_rdy;
            if (hs1 && in0_vld) wait0++;
            if (hs0 && in1_vld) wait1++;
            if (wait0 > max0) max0 = wait0;
            if (wait1 > max1) max1 = wait1;
            if (hs0) wait0 = 0;
            if (hs1) wait1 = 0;
            sb_step();
            @(negedge clk);
        end
        in0_vld = 1'b0; in1_vld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            out0_rdy = 1'b1;
            #1;
            sb_step();
            @(negedge clk);
        end
        check("t6_sb_empty", 512'(sb_q.size()), 512'(0));
        check("t6_starve0", 512'(max0 <= 1), 512'(1'b1));
        check("t6_starve1", 512'(max1 <= 1), 512'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
